// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings for the fetch/execute phase sequencer.
package cycle_sequencer_pkg;

  localparam int unsigned FE_STATE_BITS   = 3;
  localparam int unsigned EX_STATE_BITS   = 3;
  localparam int unsigned CTRL_STATE_BITS = 2;

  typedef enum logic [FE_STATE_BITS-1:0] {
    FE_IDLE = 3'd0,
    FE_Q1   = 3'd1,
    FE_Q2   = 3'd2,
    FE_Q3   = 3'd3,
    FE_Q4   = 3'd4
  } fe_state_e;

  typedef enum logic [EX_STATE_BITS-1:0] {
    EX_IDLE = 3'd0,
    EX_Q1   = 3'd1,
    EX_Q2   = 3'd2,
    EX_Q3   = 3'd3,
    EX_Q4   = 3'd4
  } ex_state_e;

  typedef enum logic [CTRL_STATE_BITS-1:0] {
    CTRL_START = 2'd0,
    CTRL_RUN   = 2'd1,
    CTRL_SLEEP = 2'd2
  } ctrl_state_e;

  // Next fetch phase; anything unexpected restarts at Q1.
  function automatic fe_state_e fe_advance(fe_state_e s);
    case (s)
      FE_Q1:   return FE_Q2;
      FE_Q2:   return FE_Q3;
      FE_Q3:   return FE_Q4;
      default: return FE_Q1;
    endcase
  endfunction

  // Execute phase that runs in lockstep with a given fetch phase.
  function automatic ex_state_e ex_from_fe(fe_state_e s);
    case (s)
      FE_Q1:   return EX_Q1;
      FE_Q2:   return EX_Q2;
      FE_Q3:   return EX_Q3;
      FE_Q4:   return EX_Q4;
      default: return EX_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cycle_sequencer_startup_timer.sv
// Saturating up-counter with clear/enable; done once LIMIT-1 is reached.
module cycle_sequencer_startup_timer #(
  parameter int unsigned LIMIT = 18,
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic done_c_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign done_c_o = (count_q >= WIDTH'(LIMIT - 1));

endmodule

// File: rtl/cycle_sequencer.sv
// Four-phase fetch/execute timing, flush qualifiers, start-up delay and SLEEP.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned STARTUP_CYCLES = 18,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     goto_req,
  input  logic                     skip_req,
  input  logic                     sleep_req,
  input  logic                     wake,
  output logic [FE_STATE_BITS-1:0] fetchState,
  output logic [EX_STATE_BITS-1:0] executeState,
  output logic                     goto,
  output logic                     skip,
  output logic                     sleeping,
  output logic                     cycle_tick
);

  ctrl_state_e st_q, st_d;
  fe_state_e   fe_q, fe_d;
  ex_state_e   ex_q, ex_d;
  logic        pv_q, pv_d;
  logic        goto_flag_q, goto_flag_d;
  logic        skip_flag_q, skip_flag_d;
  logic        sleeping_q, sleeping_d;
  logic        goto_q, goto_d;
  logic        skip_q, skip_d;
  logic        tick_q, tick_d;
  logic        tmr_clr_c, tmr_en_c, tmr_done_c;

  cycle_sequencer_startup_timer #(
    .LIMIT (STARTUP_CYCLES),
    .WIDTH (CNT_WIDTH)
  ) u_startup_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (tmr_clr_c),
    .en_i     (tmr_en_c),
    .done_c_o (tmr_done_c)
  );

  // Controller next state, phase sequencing, flush capture and output decode.
  always_comb begin
    st_d        = st_q;
    fe_d        = fe_q;
    ex_d        = ex_q;
    pv_d        = pv_q;
    goto_flag_d = goto_flag_q;
    skip_flag_d = skip_flag_q;
    sleeping_d  = sleeping_q;
    tmr_clr_c   = 1'b0;
    tmr_en_c    = 1'b0;

    case (st_q)
      CTRL_START: begin
        tmr_en_c   = 1'b1;
        fe_d       = FE_IDLE;
        ex_d       = EX_IDLE;
        sleeping_d = 1'b0;
        if (tmr_done_c) begin
          st_d      = CTRL_RUN;
          tmr_clr_c = 1'b1;
          fe_d      = FE_Q1;
          ex_d      = pv_q ? EX_Q1 : EX_IDLE;
        end
      end
      CTRL_RUN: begin
        fe_d = fe_advance(fe_q);
        // Execute stays idle until the first fetch completes.
        if (pv_q || (fe_q == FE_Q4)) ex_d = ex_from_fe(fe_d);
        if (fe_q == FE_Q4) pv_d = 1'b1;
        if ((ex_q == EX_Q2) || (ex_q == EX_Q3) || (ex_q == EX_Q4)) begin
          goto_flag_d = goto_flag_q | goto_req;
          skip_flag_d = skip_flag_q | skip_req;
        end
        if (ex_q == EX_Q1) begin
          goto_flag_d = 1'b0;
          skip_flag_d = 1'b0;
        end
        if ((ex_q == EX_Q4) && sleep_req) begin
          st_d       = CTRL_SLEEP;
          fe_d       = FE_IDLE;
          ex_d       = EX_IDLE;
          sleeping_d = 1'b1;
        end
      end
      CTRL_SLEEP: begin
        fe_d = FE_IDLE;
        ex_d = EX_IDLE;
        if (wake) begin
          st_d       = CTRL_START;
          sleeping_d = 1'b0;
          tmr_clr_c  = 1'b1;
        end
      end
      default: begin
        st_d       = CTRL_START;
        fe_d       = FE_IDLE;
        ex_d       = EX_IDLE;
        sleeping_d = 1'b0;
        tmr_clr_c  = 1'b1;
      end
    endcase

    goto_d = (ex_d == EX_Q1) && goto_flag_d;
    skip_d = (ex_d == EX_Q1) && skip_flag_d;
    tick_d = (ex_d == EX_Q1) && pv_q;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= CTRL_START;
      fe_q        <= FE_IDLE;
      ex_q        <= EX_IDLE;
      pv_q        <= 1'b0;
      goto_flag_q <= 1'b0;
      skip_flag_q <= 1'b0;
      sleeping_q  <= 1'b0;
      goto_q      <= 1'b0;
      skip_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      fe_q        <= fe_d;
      ex_q        <= ex_d;
      pv_q        <= pv_d;
      goto_flag_q <= goto_flag_d;
      skip_flag_q <= skip_flag_d;
      sleeping_q  <= sleeping_d;
      goto_q      <= goto_d;
      skip_q      <= skip_d;
      tick_q      <= tick_d;
    end
  end

  assign fetchState   = fe_q;
  assign executeState = ex_q;
  assign goto         = goto_q;
  assign skip         = skip_q;
  assign sleeping     = sleeping_q;
  assign cycle_tick   = tick_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: time-indexed reference model plus directed checks.
module tb_cycle_sequencer;
  import cycle_sequencer_pkg::*;

  localparam int unsigned STARTUP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic goto_req = 1'b0, skip_req = 1'b0, sleep_req = 1'b0, wake = 1'b0;
  logic [FE_STATE_BITS-1:0] fetchState;
  logic [EX_STATE_BITS-1:0] executeState;
  logic goto, skip, sleeping, cycle_tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cycle_sequencer #(
    .STARTUP_CYCLES (STARTUP),
    .CNT_WIDTH      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .goto_req     (goto_req),
    .skip_req     (skip_req),
    .sleep_req    (sleep_req),
    .wake         (wake),
    .fetchState   (fetchState),
    .executeState (executeState),
    .goto         (goto),
    .skip         (skip),
    .sleeping     (sleeping),
    .cycle_tick   (cycle_tick)
  );

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run_t counts clocks since entering the run phase
  // (-1 when not running); phase = run_t mod 4.
  int m_run_t = -1;
  int m_start = 0;
  bit m_sleep = 1'b0, m_pv = 1'b0, m_pg = 1'b0, m_ps = 1'b0;
  int e_fe = 0, e_ex = 0;
  bit e_goto = 1'b0, e_skip = 1'b0, e_tick = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int o_ex, o_fe;
    bit o_pv;
    if (!rst_n) begin
      m_run_t = -1; m_start = 0;
      m_sleep = 1'b0; m_pv = 1'b0; m_pg = 1'b0; m_ps = 1'b0;
      e_fe = 0; e_ex = 0; e_goto = 1'b0; e_skip = 1'b0; e_tick = 1'b0;
    end else begin
      o_ex = e_ex; o_fe = e_fe; o_pv = m_pv;
      if (m_sleep) begin
        if (wake) begin m_sleep = 1'b0; m_start = 0; end
      end else if (m_run_t < 0) begin
        if (m_start >= int'(STARTUP) - 1) begin m_run_t = 0; m_start = 0; end
        else m_start++;
      end else begin
        if (o_ex >= 2) begin m_pg = m_pg | goto_req; m_ps = m_ps | skip_req; end
        if (o_ex == 1) begin m_pg = 1'b0; m_ps = 1'b0; end
        if (o_fe == 4) m_pv = 1'b1;
        if (o_ex == 4 && sleep_req) begin m_sleep = 1'b1; m_run_t = -1; end
        else m_run_t++;
      end
      e_fe   = (m_run_t >= 0) ? (m_run_t % 4) + 1 : 0;
      e_ex   = (m_run_t >= 0 && m_pv) ? e_fe : 0;
      e_tick = (e_ex == 1) && o_pv;
      e_goto = (e_ex == 1) && m_pg;
      e_skip = (e_ex == 1) && m_ps;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_fetchState",   int'(fetchState),   e_fe);
    check("model_executeState", int'(executeState), e_ex);
    check("model_goto",         int'(goto),         int'(e_goto));
    check("model_skip",         int'(skip),         int'(e_skip));
    check("model_sleeping",     int'(sleeping),     int'(m_sleep));
    check("model_cycle_tick",   int'(cycle_tick),   int'(e_tick));
  end

  task automatic wait_ex(int target);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (e_ex != target && k < 24);
    if (e_ex != target) check("wait_ex_timeout", e_ex, target);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_fe"},    int'(fetchState),   0);
    check({tag, "_ex"},    int'(executeState), 0);
    check({tag, "_goto"},  int'(goto),         0);
    check({tag, "_skip"},  int'(skip),         0);
    check({tag, "_sleep"}, int'(sleeping),     0);
    check({tag, "_tick"},  int'(cycle_tick),   0);
  endtask

  int fe_tab[12]   = '{0, 0, 0, 1, 2, 3, 4, 1, 2, 3, 4, 1};
  int ex_tab[12]   = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 4, 1};
  int tick_tab[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int cnt;

    // Reset and start-up fill, clocks 1..12 after release.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check("clk0_fe", int'(fetchState), 0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("fill_fe_clk%0d", c + 1), int'(fetchState), fe_tab[c]);
      check($sformatf("fill_ex_clk%0d", c + 1), int'(executeState), ex_tab[c]);
      check($sformatf("fill_tick_clk%0d", c + 1), int'(cycle_tick), tick_tab[c]);
    end

    // goto in EX_Q3 (wake during RUN must be ignored).
    wait_ex(3);
    goto_req = 1'b1; wake = 1'b1;
    @(negedge clk);
    goto_req = 1'b0; wake = 1'b0;
    wait_ex(1);
    check("goto_q3_pulse", int'(goto), 1);
    check("goto_q3_noskip", int'(skip), 0);
    @(negedge clk);
    check("goto_q3_onecycle", int'(goto), 0);

    // goto + skip together in EX_Q2.
    wait_ex(2);
    goto_req = 1'b1; skip_req = 1'b1;
    @(negedge clk);
    goto_req = 1'b0; skip_req = 1'b0;
    wait_ex(1);
    check("both_goto", int'(goto), 1);
    check("both_skip", int'(skip), 1);
    // Request during EX_Q1 is ignored.
    goto_req = 1'b1;
    @(negedge clk);
    goto_req = 1'b0;
    wait_ex(1);
    check("q1_req_ignored", int'(goto), 0);

    // SLEEP entry, quiet period, wake.
    wait_ex(4);
    sleep_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0;
    check("sleep_flag", int'(sleeping), 1);
    check("sleep_fe_idle", int'(fetchState), 0);
    check("sleep_ex_idle", int'(executeState), 0);
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(cycle_tick); end
    check("sleep_ticks", cnt, 0);
    wake = 1'b1;
    @(negedge clk);
    wake = 1'b0;
    check("wake_clears_sleep", int'(sleeping), 0);
    repeat (3) @(negedge clk);
    check("wake_still_idle", int'(fetchState), 0);
    @(negedge clk);
    check("resume_fe_q1", int'(fetchState), 1);
    check("resume_ex_q1", int'(executeState), 1);

    // SLEEP together with skip: skip appears on first EX_Q1 after resume.
    wait_ex(4);
    sleep_req = 1'b1; skip_req = 1'b1;
    @(negedge clk);
    sleep_req = 1'b0; skip_req = 1'b0;
    check("sleepskip_sleeping", int'(sleeping), 1);
    check("sleepskip_held", int'(skip), 0);
    repeat (5) @(negedge clk);
    wake = 1'b1;
    @(negedge clk);
    wake = 1'b0;
    repeat (4) @(negedge clk);
    check("sleepskip_ex_q1", int'(executeState), 1);
    check("sleepskip_skip", int'(skip), 1);
    check("sleepskip_nogoto", int'(goto), 0);
    @(negedge clk);
    check("sleepskip_cleared", int'(skip), 0);

    // Async reset in FE_Q3 with goto pending.
    wait_ex(2);
    goto_req = 1'b1;
    @(negedge clk);
    goto_req = 1'b0;
    check("pre_reset_fe_q3", int'(fetchState), 3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (24) begin @(negedge clk); cnt += int'(goto); end
    check("no_goto_after_reset", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
